// File: rtl/match_game_fsm_if.sv
// Pick channel between the key decoder and the tile-matching controller.
// The decoder offers a one-cycle sel_valid strobe with sel_idx; there is no backpressure.
interface match_game_fsm_if #(
    parameter int IDX_W = 6
);
    // valid/ready contract: sel_valid is a single-cycle offer qualified by sel_idx.
    // A refused offer in PICK1/PICK2 is answered by sel_reject high for the following cycle.
    // Accepted offers, and any offer made outside PICK1/PICK2, produce no response.
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_reject;

    modport master (output sel_valid, output sel_idx, input sel_reject);
    modport slave  (input sel_valid, input sel_idx, output sel_reject);
endinterface

// File: rtl/match_game_fsm.sv
// Tile-matching game controller: first/second picks, timed lockout and reveal,
// matched mask, move counting, and win/loss detection.
module match_game_fsm #(
    parameter int NUM_TILES  = 16,
    parameter int IDX_W      = 6,
    parameter int COLOR_W    = 3,
    parameter int LOCK_CYC   = 25000000,
    parameter int SHOW_CYC   = 100000000,
    parameter int SCORE_W    = 8,
    parameter int MOVE_LIMIT = 0
) (
    input  logic                         CLOCK_50,
    input  logic                         userquit,
    input  logic                         game_on,
    match_game_fsm_if.slave              pick,
    input  logic [NUM_TILES*COLOR_W-1:0] tile_colors,
    output logic [NUM_TILES-1:0]         matched,
    output logic [NUM_TILES-1:0]         revealed,
    output logic [IDX_W-1:0]             first_idx,
    output logic [IDX_W-1:0]             second_idx,
    output logic [COLOR_W-1:0]           first_color,
    output logic [COLOR_W-1:0]           second_color,
    output logic [SCORE_W-1:0]           moves,
    output logic [IDX_W-1:0]             pairs_left,
    output logic                         match_pulse,
    output logic                         mismatch_pulse,
    output logic                         game_over,
    output logic                         game_won,
    output logic [2:0]                   state
);
    typedef enum logic [2:0] {
        S_PICK1   = 3'd0,
        S_PICK2   = 3'd1,
        S_ARM     = 3'd2,
        S_SHOW    = 3'd3,
        S_OVER    = 3'd4,
        S_IDLE    = 3'd5,
        S_COMPARE = 3'd6
    } state_t;

    localparam int MAX_CYC = (LOCK_CYC > SHOW_CYC) ? LOCK_CYC : SHOW_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [IDX_W-1:0] PAIRS_INIT = IDX_W'(NUM_TILES / 2);
    localparam logic [NUM_TILES-1:0] ONE    = NUM_TILES'(1);

    state_t               st;
    logic [CNT_W-1:0]     cnt;
    logic                 first_held;
    logic                 second_held;
    logic [NUM_TILES-1:0] pick_oh;
    logic [NUM_TILES-1:0] first_oh;
    logic [NUM_TILES-1:0] second_oh;
    logic [COLOR_W-1:0]   pick_color;
    logic                 pick_in_range;
    logic                 pick_ok;

    // Shifting a one-hot keeps out-of-range indices harmless (they shift to zero).
    assign pick_oh       = ONE << pick.sel_idx;
    assign pick_in_range = ({1'b0, pick.sel_idx} < (IDX_W + 1)'(NUM_TILES));
    assign pick_ok       = pick_in_range && ((pick_oh & matched) == '0);
    assign first_oh      = first_held  ? (ONE << first_idx)  : '0;
    assign second_oh     = second_held ? (ONE << second_idx) : '0;
    assign revealed      = matched | first_oh | second_oh;
    assign state         = st;

    always_comb begin
        pick_color = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (pick.sel_idx == IDX_W'(i)) pick_color = tile_colors[i*COLOR_W +: COLOR_W];
        end
    end

    always_ff @(posedge CLOCK_50 or posedge userquit) begin
        if (userquit) begin
            st              <= S_IDLE;
            cnt             <= '0;
            matched         <= '0;
            first_idx       <= '0;
            second_idx      <= '0;
            first_color     <= '0;
            second_color    <= '0;
            first_held      <= 1'b0;
            second_held     <= 1'b0;
            moves           <= '0;
            pairs_left      <= PAIRS_INIT;
            match_pulse     <= 1'b0;
            mismatch_pulse  <= 1'b0;
            pick.sel_reject <= 1'b0;
            game_over       <= 1'b0;
            game_won        <= 1'b0;
        end else begin
            match_pulse     <= 1'b0;
            mismatch_pulse  <= 1'b0;
            pick.sel_reject <= 1'b0;
            // Dropping game_on beats any pick or timer expiry in the same cycle.
            if (st == S_IDLE || !game_on) begin
                st           <= game_on ? S_PICK1 : S_IDLE;
                cnt          <= '0;
                matched      <= '0;
                first_idx    <= '0;
                second_idx   <= '0;
                first_color  <= '0;
                second_color <= '0;
                first_held   <= 1'b0;
                second_held  <= 1'b0;
                moves        <= '0;
                pairs_left   <= PAIRS_INIT;
                game_over    <= 1'b0;
                game_won     <= 1'b0;
            end else begin
                case (st)
                    S_PICK1: begin
                        if (pick.sel_valid) begin
                            if (pick_ok) begin
                                first_idx   <= pick.sel_idx;
                                first_color <= pick_color;
                                first_held  <= 1'b1;
                                cnt         <= '0;
                                st          <= S_ARM;
                            end else begin
                                pick.sel_reject <= 1'b1;
                            end
                        end
                    end
                    S_ARM: begin
                        if (cnt == LOCK_LAST) st <= S_PICK2;
                        else                  cnt <= cnt + 1'b1;
                    end
                    S_PICK2: begin
                        if (pick.sel_valid) begin
                            if (pick_ok && (pick.sel_idx != first_idx)) begin
                                second_idx   <= pick.sel_idx;
                                second_color <= pick_color;
                                second_held  <= 1'b1;
                                st           <= S_COMPARE;
                            end else begin
                                pick.sel_reject <= 1'b1;
                            end
                        end
                    end
                    S_COMPARE: begin
                        if (moves != '1) moves <= moves + 1'b1;
                        if (first_color == second_color) begin
                            matched     <= matched | first_oh | second_oh;
                            pairs_left  <= pairs_left - 1'b1;
                            match_pulse <= 1'b1;
                        end else begin
                            mismatch_pulse <= 1'b1;
                        end
                        cnt <= '0;
                        st  <= S_SHOW;
                    end
                    S_SHOW: begin
                        if (cnt == SHOW_LAST) begin
                            first_idx    <= '0;
                            second_idx   <= '0;
                            first_color  <= '0;
                            second_color <= '0;
                            first_held   <= 1'b0;
                            second_held  <= 1'b0;
                            if (pairs_left == '0) begin
                                st        <= S_OVER;
                                game_over <= 1'b1;
                                game_won  <= 1'b1;
                            end else if (MOVE_LIMIT != 0 && int'(moves) >= MOVE_LIMIT) begin
                                st        <= S_OVER;
                                game_over <= 1'b1;
                                game_won  <= 1'b0;
                            end else begin
                                st <= S_PICK1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_OVER: begin
                        st <= S_OVER;
                    end
                    default: st <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_match_game_fsm.sv
// Bench for match_game_fsm: directed scenarios plus random games checked against
// a turn-level model of the game rules (matched set, move count, pairs, outcome).
module tb_match_game_fsm;
    localparam int NT = 4;
    localparam int IW = 2;
    localparam int CW = 2;
    localparam int LC = 3;
    localparam int SC = 5;
    localparam int SW = 8;
    localparam logic [33:0] RST_VEC = {3'd5, 4'd0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 8'd0, 2'd2, 5'd0};

    // clock / reset
    logic CLOCK_50 = 1'b0;
    logic userquit = 1'b1;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic ga = 1'b0, gb = 1'b0, use_b = 1'b0, sv = 1'b0;
    logic [IW-1:0] si = '0;
    logic [NT*CW-1:0] tile_colors = {2'd2, 2'd1, 2'd2, 2'd1};

    match_game_fsm_if #(.IDX_W(IW)) pa ();
    match_game_fsm_if #(.IDX_W(IW)) pb ();
    assign pa.sel_valid = sv & ~use_b;
    assign pa.sel_idx   = si;
    assign pb.sel_valid = sv & use_b;
    assign pb.sel_idx   = si;

    logic [NT-1:0] a_matched, a_revealed, b_matched, b_revealed;
    logic [IW-1:0] a_first_idx, a_second_idx, a_pairs, b_first_idx, b_second_idx, b_pairs;
    logic [CW-1:0] a_first_color, a_second_color, b_first_color, b_second_color;
    logic [SW-1:0] a_moves, b_moves;
    logic a_mp, a_mmp, a_over, a_won, b_mp, b_mmp, b_over, b_won;
    logic [2:0] a_state, b_state;

    match_game_fsm #(.NUM_TILES(NT), .IDX_W(IW), .COLOR_W(CW), .LOCK_CYC(LC), .SHOW_CYC(SC),
                     .SCORE_W(SW), .MOVE_LIMIT(0)) dut (
        .CLOCK_50(CLOCK_50), .userquit(userquit), .game_on(ga), .pick(pa.slave),
        .tile_colors(tile_colors), .matched(a_matched), .revealed(a_revealed),
        .first_idx(a_first_idx), .second_idx(a_second_idx), .first_color(a_first_color),
        .second_color(a_second_color), .moves(a_moves), .pairs_left(a_pairs),
        .match_pulse(a_mp), .mismatch_pulse(a_mmp), .game_over(a_over), .game_won(a_won),
        .state(a_state));

    match_game_fsm #(.NUM_TILES(NT), .IDX_W(IW), .COLOR_W(CW), .LOCK_CYC(LC), .SHOW_CYC(SC),
                     .SCORE_W(SW), .MOVE_LIMIT(1)) dut_lim (
        .CLOCK_50(CLOCK_50), .userquit(userquit), .game_on(gb), .pick(pb.slave),
        .tile_colors(tile_colors), .matched(b_matched), .revealed(b_revealed),
        .first_idx(b_first_idx), .second_idx(b_second_idx), .first_color(b_first_color),
        .second_color(b_second_color), .moves(b_moves), .pairs_left(b_pairs),
        .match_pulse(b_mp), .mismatch_pulse(b_mmp), .game_over(b_over), .game_won(b_won),
        .state(b_state));

    // Observation view of whichever instance is under test.
    logic [2:0] o_state;
    logic [NT-1:0] o_matched, o_revealed;
    logic [IW-1:0] o_first_idx, o_second_idx, o_pairs;
    logic [CW-1:0] o_first_color, o_second_color;
    logic [SW-1:0] o_moves;
    logic o_mp, o_mmp, o_rej, o_over, o_won;
    logic [33:0] o_all;
    assign o_state        = use_b ? b_state        : a_state;
    assign o_matched      = use_b ? b_matched      : a_matched;
    assign o_revealed     = use_b ? b_revealed     : a_revealed;
    assign o_first_idx    = use_b ? b_first_idx    : a_first_idx;
    assign o_second_idx   = use_b ? b_second_idx   : a_second_idx;
    assign o_first_color  = use_b ? b_first_color  : a_first_color;
    assign o_second_color = use_b ? b_second_color : a_second_color;
    assign o_moves        = use_b ? b_moves        : a_moves;
    assign o_pairs        = use_b ? b_pairs        : a_pairs;
    assign o_mp           = use_b ? b_mp           : a_mp;
    assign o_mmp          = use_b ? b_mmp          : a_mmp;
    assign o_rej          = use_b ? pb.sel_reject  : pa.sel_reject;
    assign o_over         = use_b ? b_over         : a_over;
    assign o_won          = use_b ? b_won          : a_won;
    assign o_all = {o_state, o_matched, o_revealed, o_first_idx, o_second_idx, o_first_color,
                    o_second_color, o_moves, o_pairs, o_mp, o_mmp, o_rej, o_over, o_won};

    int checks = 0;
    int errors = 0;

    // Turn-level game model.
    int col[NT] = '{1, 2, 1, 2};
    bit m_matched[NT];
    int m_moves, m_pairs, m_limit;

    function automatic void m_new_game(int lim);
        foreach (m_matched[i]) m_matched[i] = 1'b0;
        m_moves = 0;
        m_pairs = NT / 2;
        m_limit = lim;
    endfunction

    function automatic logic [NT-1:0] m_mask();
        logic [NT-1:0] v = '0;
        foreach (m_matched[i]) v[i] = m_matched[i];
        return v;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic offer(input int idx);
        sv = 1'b1;
        si = IW'(idx);
        tick();
        sv = 1'b0;
    endtask

    task automatic start_game(input bit b);
        use_b = b;
        ga = 1'b0;
        gb = 1'b0;
        tick();
        checks++;
        if ({o_state, o_moves, o_matched, o_pairs, o_over} !== {3'd5, 8'd0, 4'd0, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL idle_cleared: got st=%0d mv=%0d m=%b p=%0d ov=%b, expected st=5 mv=0 m=0000 p=2 ov=0",
                     o_state, o_moves, o_matched, o_pairs, o_over);
        end
        if (b) gb = 1'b1; else ga = 1'b1;
        tick();
        checks++;
        if (o_state !== 3'd0) begin
            errors++;
            $display("FAIL enter_pick1: got st=%0d expected 0", o_state);
        end
        m_new_game(b ? 1 : 0);
    endtask

    // One complete turn with picks a then b (both legal); noise adds refused offers.
    task automatic play_turn(input int a, input int b, input bit noise);
        logic [NT-1:0] exp_rev;
        bit eq, exp_over, exp_won;
        int exp_st;
        if (noise) begin
            for (int j = 0; j < NT; j++) begin
                if (m_matched[j]) begin
                    offer(j);
                    checks++;
                    if ({o_rej, o_state} !== {1'b1, 3'd0}) begin
                        errors++;
                        $display("FAIL pick1_reject: tile %0d got rej=%b st=%0d expected rej=1 st=0", j, o_rej, o_state);
                    end
                end
            end
        end
        offer(a);
        checks++;
        if ({o_state, o_first_idx, o_first_color, o_rej, o_revealed} !==
            {3'd2, IW'(a), CW'(col[a]), 1'b0, m_mask() | NT'(1 << a)}) begin
            errors++;
            $display("FAIL first_pick: got st=%0d idx=%0d col=%0d rej=%b rev=%b expected st=2 idx=%0d col=%0d rej=0 rev=%b",
                     o_state, o_first_idx, o_first_color, o_rej, o_revealed, a, col[a], m_mask() | NT'(1 << a));
        end
        for (int k = 1; k <= LC; k++) begin
            sv = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            si = IW'($urandom_range(0, NT - 1));
            tick();
            sv = 1'b0;
            exp_st = (k < LC) ? 2 : 1;
            checks++;
            if ({o_state, o_rej} !== {3'(exp_st), 1'b0}) begin
                errors++;
                $display("FAIL arm_timing: cycle %0d got st=%0d rej=%b expected st=%0d rej=0", k, o_state, o_rej, exp_st);
            end
        end
        if (noise) begin
            for (int j = 0; j < NT; j++) begin
                if (j == a || m_matched[j]) begin
                    offer(j);
                    checks++;
                    if ({o_rej, o_state, o_first_idx} !== {1'b1, 3'd1, IW'(a)}) begin
                        errors++;
                        $display("FAIL pick2_reject: tile %0d got rej=%b st=%0d first=%0d expected rej=1 st=1 first=%0d",
                                 j, o_rej, o_state, o_first_idx, a);
                    end
                end
            end
        end
        offer(b);
        exp_rev = m_mask() | NT'(1 << a) | NT'(1 << b);
        checks++;
        if ({o_state, o_second_idx, o_second_color, o_revealed} !== {3'd6, IW'(b), CW'(col[b]), exp_rev}) begin
            errors++;
            $display("FAIL second_pick: got st=%0d idx=%0d col=%0d rev=%b expected st=6 idx=%0d col=%0d rev=%b",
                     o_state, o_second_idx, o_second_color, o_revealed, b, col[b], exp_rev);
        end
        tick();
        eq = (col[a] == col[b]);
        if (m_moves < 255) m_moves++;
        if (eq) begin
            m_matched[a] = 1'b1;
            m_matched[b] = 1'b1;
            m_pairs--;
        end
        checks++;
        if ({o_state, o_mp, o_mmp, o_moves, o_matched, o_pairs, o_revealed} !==
            {3'd3, eq, ~eq, SW'(m_moves), m_mask(), IW'(m_pairs), exp_rev}) begin
            errors++;
            $display("FAIL compare: got st=%0d mp=%b mmp=%b mv=%0d m=%b p=%0d rev=%b expected st=3 mp=%b mmp=%b mv=%0d m=%b p=%0d rev=%b",
                     o_state, o_mp, o_mmp, o_moves, o_matched, o_pairs, o_revealed,
                     eq, ~eq, m_moves, m_mask(), m_pairs, exp_rev);
        end
        exp_won  = (m_pairs == 0);
        exp_over = exp_won || (m_limit != 0 && m_moves >= m_limit);
        for (int k = 1; k <= SC; k++) begin
            tick();
            if (k < SC) begin
                checks++;
                if ({o_state, o_mp, o_mmp, o_revealed} !== {3'd3, 1'b0, 1'b0, exp_rev}) begin
                    errors++;
                    $display("FAIL show_hold: cycle %0d got st=%0d mp=%b mmp=%b rev=%b expected st=3 mp=0 mmp=0 rev=%b",
                             k, o_state, o_mp, o_mmp, o_revealed, exp_rev);
                end
            end else begin
                checks++;
                if ({o_state, o_first_idx, o_second_idx, o_first_color, o_second_color, o_revealed, o_over, o_won} !==
                    {exp_over ? 3'd4 : 3'd0, 8'd0, m_mask(), exp_over, exp_won}) begin
                    errors++;
                    $display("FAIL show_end: got st=%0d f=%0d s=%0d fc=%0d sc=%0d rev=%b ov=%b won=%b expected st=%0d picks=0 rev=%b ov=%b won=%b",
                             o_state, o_first_idx, o_second_idx, o_first_color, o_second_color, o_revealed,
                             o_over, o_won, exp_over ? 4 : 0, m_mask(), exp_over, exp_won);
                end
            end
        end
    endtask

    // scenarios
    task automatic test_reset();
        userquit = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            use_b = (d == 1);
            #1;
            checks++;
            if (o_all !== RST_VEC) begin
                errors++;
                $display("FAIL reset_values: dut%0d got %h expected %h", d, o_all, RST_VEC);
            end
        end
        use_b = 1'b0;
        userquit = 1'b0;
    endtask

    task automatic test_match();
        start_game(1'b0);
        play_turn(0, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        play_turn(1, 3, 1'b1);
    endtask

    task automatic test_game_over();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({o_state, o_over, o_won, o_matched, o_moves} !== {3'd4, 1'b1, 1'b1, 4'b1111, 8'd2}) begin
                errors++;
                $display("FAIL over_hold: got st=%0d ov=%b won=%b m=%b mv=%0d expected st=4 ov=1 won=1 m=1111 mv=2",
                         o_state, o_over, o_won, o_matched, o_moves);
            end
        end
        ga = 1'b0;
        tick();
        checks++;
        if ({o_state, o_moves, o_over, o_won} !== {3'd5, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL over_exit: got st=%0d mv=%0d ov=%b won=%b expected st=5 mv=0 ov=0 won=0",
                     o_state, o_moves, o_over, o_won);
        end
    endtask

    task automatic test_mismatch();
        start_game(1'b0);
        play_turn(0, 1, 1'b0);
    endtask

    task automatic test_move_limit();
        start_game(1'b1);
        play_turn(0, 1, 1'b0);
        checks++;
        if ({b_state, b_over, b_won, b_moves} !== {3'd4, 1'b1, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL limit_loss: got st=%0d ov=%b won=%b mv=%0d expected st=4 ov=1 won=0 mv=1",
                     b_state, b_over, b_won, b_moves);
        end
        gb = 1'b0;
        use_b = 1'b0;
    endtask

    task automatic test_abort();
        // game_on dropped while in COMPARE: no score update
        start_game(1'b0);
        offer(0);
        repeat (LC) tick();
        offer(2);
        ga = 1'b0;
        tick();
        checks++;
        if ({o_state, o_matched, o_moves, o_mp, o_mmp} !== {3'd5, 4'd0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL compare_abort: got st=%0d m=%b mv=%0d mp=%b mmp=%b expected st=5 m=0000 mv=0 pulses 0",
                     o_state, o_matched, o_moves, o_mp, o_mmp);
        end
        // userquit mid-SHOW takes effect without a clock edge
        start_game(1'b0);
        offer(0);
        repeat (LC) tick();
        offer(2);
        tick();
        tick();
        #2 userquit = 1'b1;
        #1;
        checks++;
        if (o_all !== RST_VEC) begin
            errors++;
            $display("FAIL async_quit: got %h expected %h", o_all, RST_VEC);
        end
        userquit = 1'b0;
        tick();
        checks++;
        if ({o_state, o_mp, o_mmp, o_matched} !== {3'd0, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL quit_release: got st=%0d mp=%b mmp=%b m=%b expected st=0 no pulses m=0000",
                     o_state, o_mp, o_mmp, o_matched);
        end
        // game_on low beats a simultaneous pick in PICK1
        ga = 1'b0;
        offer(3);
        checks++;
        if ({o_state, o_first_idx, o_rej} !== {3'd5, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL gameoff_pick: got st=%0d first=%0d rej=%b expected st=5 first=0 rej=0",
                     o_state, o_first_idx, o_rej);
        end
    endtask

    task automatic test_random_games();
        int a, b;
        for (int g = 0; g < 4; g++) begin
            start_game(1'b0);
            for (int t = 0; t < 40 && m_pairs > 0; t++) begin
                do a = $urandom_range(0, NT - 1); while (m_matched[a]);
                do b = $urandom_range(0, NT - 1); while (m_matched[b] || b == a);
                play_turn(a, b, 1'($urandom_range(0, 1)));
            end
            checks++;
            if (o_won !== (m_pairs == 0)) begin
                errors++;
                $display("FAIL random_outcome: game %0d got won=%b expected %b", g, o_won, m_pairs == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_back_to_back();
        test_game_over();
        test_mismatch();
        test_move_limit();
        test_abort();
        test_random_games();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
